// File: rtl/ram32_burst_ctrl_pkg.sv
// Shared constants for the 32x8 RAM burst controller: op encodings, FSM states, default widths.
package ram32_burst_ctrl_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 8;
  localparam int LW_DEF = 6;

  localparam logic [1:0] OP_FILL  = 2'b00;
  localparam logic [1:0] OP_CHECK = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FILL      = 3'd1;
  localparam logic [2:0] CHK_RD    = 3'd2;
  localparam logic [2:0] CHK_DRAIN = 3'd3;
  localparam logic [2:0] CP_RD     = 3'd4;
  localparam logic [2:0] CP_WR     = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

endpackage

// File: rtl/ram32.sv
// 32x8 single-port synchronous RAM; d_out is valid the cycle after a read is presented.
module ram32 (
  input  logic       clk,
  input  logic       wr_rd,
  input  logic [4:0] addr,
  input  logic [7:0] d_in,
  output logic [7:0] d_out
);

  logic [7:0] mem [32];

  always_ff @(posedge clk) begin
    if (wr_rd) mem[addr] <= d_in;
    else       d_out     <= mem[addr];
  end

endmodule

// File: rtl/ram32_burst_ctrl.sv
// Burst fill/check/copy initiator for the 32x8 RAM.
// Optional: define RAMCTL_INC_PATTERN_EN for an incrementing fill/check pattern (pattern+i).
module ram32_burst_ctrl
  import ram32_burst_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] pattern,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] err_addr,
  output logic          ram_wr_rd,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [LW-1:0] MAX_LEN = LW'(2**AW);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [LW-1:0] len_q, len_d, idx_q, idx_d;
  logic [DW-1:0] pat_q, pat_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          err_q, err_d;
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          cpwr_q, cpwr_d;
  logic          cmp_valid_q, cmp_valid_d;
  logic [AW-1:0] cmp_addr_q, cmp_addr_d;
  logic [DW-1:0] cmp_exp_q, cmp_exp_d;

  logic [LW-1:0] len_sat, idx_nxt;
  logic          last;
  logic [DW-1:0] cur_pat, nxt_pat;

  assign len_sat = (len > MAX_LEN) ? MAX_LEN : len;
  assign idx_nxt = idx_q + LW'(1);
  assign last    = (idx_nxt == len_q);

`ifdef RAMCTL_INC_PATTERN_EN
  assign cur_pat = pat_q + DW'(idx_q);
  assign nxt_pat = pat_q + DW'(idx_nxt);
`else
  assign cur_pat = pat_q;
  assign nxt_pat = pat_q;
`endif

  // Read data arrives one cycle late, so the compare stage remembers the address/expectation of the previous read.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    idx_d       = idx_q;
    pat_d       = pat_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    wr_d        = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
    cpwr_d      = 1'b0;
    cmp_valid_d = (state_q == CHK_RD);
    cmp_addr_d  = addr_q;
    cmp_exp_d   = cur_pat;

    if (cmp_valid_q && !err_q && (ram_rdata != cmp_exp_q)) begin
      err_d      = 1'b1;
      err_addr_d = cmp_addr_q;
    end

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          src_d      = src_addr;
          dst_d      = dst_addr;
          len_d      = len_sat;
          pat_d      = pattern;
          idx_d      = '0;
          err_d      = 1'b0;
          err_addr_d = '0;
          if (len_sat == '0 || op == OP_RSVD) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
            addr_d = src_addr;
            case (op)
              OP_FILL: begin
                state_d = FILL;
                wr_d    = 1'b1;
                wdata_d = pattern;
              end
              OP_CHECK: state_d = CHK_RD;
              default:  state_d = CP_RD;
            endcase
          end
        end
      end
      FILL: begin
        if (last) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          wr_d    = 1'b1;
          addr_d  = src_q + idx_nxt[AW-1:0];
          wdata_d = nxt_pat;
          idx_d   = idx_nxt;
        end
      end
      CHK_RD: begin
        if (last) begin
          state_d = CHK_DRAIN;
        end else begin
          addr_d = src_q + idx_nxt[AW-1:0];
          idx_d  = idx_nxt;
        end
      end
      CHK_DRAIN: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      CP_RD: begin
        state_d = CP_WR;
        wr_d    = 1'b1;
        cpwr_d  = 1'b1;
        addr_d  = dst_q + idx_q[AW-1:0];
      end
      CP_WR: begin
        if (last) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = CP_RD;
          addr_d  = src_q + idx_nxt[AW-1:0];
          idx_d   = idx_nxt;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      pat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpwr_q      <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      pat_q       <= pat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpwr_q      <= cpwr_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_exp_q   <= cmp_exp_d;
    end
  end

  // Copy write data is the RAM's registered read output, steered straight through during CP_WR.
  assign ram_wdata = cpwr_q ? ram_rdata : wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign ram_wr_rd = wr_q;
  assign ram_addr  = addr_q;

endmodule

// File: doc/ram32_burst_ctrl.md
Name: ram32_burst_ctrl

Overview:
- Initiator for the 32x8 single-port RAM interface (wr_rd / addr / d_in / d_out).
- Accepts one command (fill, check or copy) over a burst of up to 32 words and sequences the RAM accesses.
- On check, compares read data against the expected pattern and reports the first mismatch.
- Sits between the test/config logic and a 32-entry RAM on the same clock and reset.

Parameters:
- AW, 5, RAM address width; depth = 2**AW.
- DW, 8, RAM data width.
- LW, 6, length field width; must hold the value 2**AW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  command strobe; accepted only when busy=0.
- op  in  2  00 fill, 01 check, 10 copy, 11 reserved (treated as len=0 no-op).
- src_addr  in  AW  base address for fill, check, and copy source.
- dst_addr  in  AW  copy destination base; unused otherwise.
- len  in  LW  word count; 0 = no-op; values above 2**AW saturate to 2**AW.
- pattern  in  DW  fill data / check expected data.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command end.
- err  out  1  sticky check mismatch.
- err_addr  out  AW  address of the first mismatch.
- ram_wr_rd  out  1  1 = write, 0 = read; drives RAM wr_rd.
- ram_addr  out  AW  drives RAM addr.
- ram_wdata  out  DW  drives RAM d_in.
- ram_rdata  in  DW  from RAM d_out; valid the cycle after a read is presented.

Behaviour:
- Reset (async, rst=0): state IDLE; all outputs 0, including busy, done, err, err_addr, ram_wr_rd, ram_addr, ram_wdata. Reset mid-command aborts immediately; no done pulse.
- All outputs are registered.
- In IDLE: ram_wr_rd=0, ram_addr=0, ram_wdata=0. No writes ever occur outside FILL/CP_WR.
- start while busy=1 is ignored.
- On an accepted start, in the same edge: op, addresses, saturated len and pattern are latched; err and err_addr are cleared; word index i=0.
- Address arithmetic is modulo 2**AW (wrap 31->0).
- State FILL, for i = 0..len-1 on consecutive cycles: ram_wr_rd=1, ram_addr=src+i, ram_wdata=pattern.
- State CHK_RD: reads on consecutive cycles, ram_wr_rd=0, ram_addr=src+i.
  - State CHK_DRAIN follows CHK_RD for one cycle to compare the last word.
  - The compare in cycle n+1 checks ram_rdata against the expected value for read n.
  - First mismatch: err=1, err_addr=that read's address. Later mismatches do not overwrite.
- Copy alternates CP_RD and CP_WR:
  - CP_RD: ram_wr_rd=0, ram_addr=src+i.
  - CP_WR: ram_wr_rd=1, ram_addr=dst+i, ram_wdata=ram_rdata.
  - Total 2*len cycles. Overlapping regions are copied in ascending order, with no overlap protection.
- Timing:
  - busy=1 from the cycle after start through the last access or drain cycle.
  - The next cycle is state DONE: busy=0, done=1, RAM outputs return to idle values.
  - DONE returns to IDLE unconditionally; start is accepted in DONE.
  - Latency: fill = len+1 cycles start-to-done, check = len+2, copy = 2*len+1.
  - len=0 or op=11: busy stays 0; done pulses the cycle after start.
- err holds until the next accepted start or reset.

Optional Feature:
- Macro: RAMCTL_INC_PATTERN_EN.
- Defined: fill writes pattern+i and check expects pattern+i, with i = word index and DW-bit wrap (8'hFF+1 = 8'h00).
- Undefined: constant pattern for both fill and check.
- Copy is unaffected either way.

Decomposition:
- Shared package: op encodings (OP_FILL, OP_CHECK, OP_COPY, OP_RSVD); state enum (IDLE, FILL, CHK_RD, CHK_DRAIN, CP_RD, CP_WR, DONE); default AW/DW/LW constants.
- No sub-module is required.
- The bench instantiates this block with ram32 as the target memory.

Test Plan:
- Fill src=5 len=4 pattern=8'hA5 -> writes to 5,6,7,8 on 4 consecutive cycles; done 5 cycles after start; check of the same range gives err=0.
- Wrap: fill src=30 len=4 pattern=8'h3C -> writes to addresses 30,31,0,1; with the macro defined, data 3C,3D,3E,3F.
- Check mismatch: fill 0..7 with 8'h11, then single write 8'h22 at 3 and 8'h33 at 6, then check src=0 len=8 pattern=8'h11 -> err=1, err_addr=3 (not 6); done 10 cycles after start.
- Copy src=0 dst=16 len=3 after filling 0..2 with 8'h5A -> alternating R/W for 6 cycles; check src=16 len=3 pattern=8'h5A gives err=0.
- Edge commands: len=0 and op=11 give done the next cycle with busy never 1 and no writes; len=40 saturates to 32 writes; start pulsed while busy is ignored.
- Reset: rst low during the 3rd cycle of a len=8 fill -> all outputs 0 asynchronously, no done pulse, next command runs normally.
